flow_lookup_responder: RTL and testbench
========================================

// Module: flow_lookup_responder
// PURPOSE
//  Flow-table end of the lu_req/lu_entry/lu_len/lu_ack lookup interface driven by the header-parsing preprocessor.
//  Accepts one lookup at a time and scans a small masked exact-match table, one entry per cycle; lowest index wins.
//  Returns hit/index/action on a valid/ready result port, and keeps global and per-entry packet/byte statistics.
// PARAMETERS
//  OPENFLOW_MATCH_SIZE    256  width of lookup key, table key and table mask
//  C_AXIS_LEN_DATA_WIDTH  16   width of lu_len (packet length in bytes)
//  ENTRY_ADDR_WIDTH       4    log2 of table depth; NUM_ENTRIES = 2**ENTRY_ADDR_WIDTH
//  ACTION_WIDTH           32   action word stored per entry
//  DATA_WIDTH             32   width of every statistics counter
// PORTS
//  asclk          in   1      clock
//  aresetn        in   1      asynchronous active-low reset
//  lu_req         in   1      lookup request; held high by requester until lu_ack
//  lu_entry       in   OPENFLOW_MATCH_SIZE     lookup key
//  lu_len         in   C_AXIS_LEN_DATA_WIDTH   packet length
//  lu_ack         out  1      one-cycle accept pulse
//  result_valid   out  1      lookup result available
//  result_ready   in   1      downstream consumes result
//  result_hit     out  1      1 = match found
//  result_index   out  ENTRY_ADDR_WIDTH  matching entry (0 on miss)
//  result_action  out  ACTION_WIDTH      action of matching entry (0 on miss)
//  tbl_wr_en      in   1      write one table entry
//  tbl_wr_addr    in   ENTRY_ADDR_WIDTH  entry to write
//  tbl_wr_valid   in   1      entry valid bit to store
//  tbl_wr_key     in   OPENFLOW_MATCH_SIZE   key to store
//  tbl_wr_mask    in   OPENFLOW_MATCH_SIZE   1 = bit compared
//  tbl_wr_action  in   ACTION_WIDTH      action to store
//  stat_rd_addr   in   ENTRY_ADDR_WIDTH  per-entry stats select
//  stat_pkt_cnt   out  DATA_WIDTH        hits on selected entry (registered, 1-cycle latency)
//  stat_byte_cnt  out  DATA_WIDTH        bytes on selected entry (registered, 1-cycle latency)
//  hit_cnt        out  DATA_WIDTH        total hits
//  miss_cnt       out  DATA_WIDTH        total misses
// BEHAVIOUR
//  Reset (async, aresetn=0):
//   - FSM to IDLE; all entry valid bits, keys, masks, actions and counters cleared.
//   - Every output 0.
//  FSM states: IDLE -> SCAN -> RESP -> IDLE.
//  IDLE:
//   - lu_req=1 in cycle 0: latch lu_entry/lu_len, clear scan index.
//   - lu_ack=1 in cycle 1 only; state becomes SCAN in cycle 1.
//   - lu_req is never acked outside IDLE; it stays pending.
//  SCAN:
//   - Compares entry idx in cycle 1+idx.
//   - Match = valid && ((key ^ latched_entry) & mask) == 0.
//   - On first match: go to RESP with hit=1. result_valid rises in cycle 2+idx.
//   - No match after idx NUM_ENTRIES-1: RESP with hit=0, index 0, action 0. result_valid rises in cycle 1+NUM_ENTRIES.
//   - Scan index never wraps.
//  RESP:
//   - result_* held stable while result_valid=1 and result_ready=0.
//   - valid&&ready: result_valid drops next cycle, back to IDLE.
//   - A lu_req already high is sampled in that IDLE cycle; minimum request spacing is 3 cycles.
//  Stats:
//   - Update in the cycle the scan completes.
//   - hit_cnt++ or miss_cnt++.
//   - On hit: that entry's pkt_cnt++ and byte_cnt += zero-extended lu_len.
//   - All counters wrap modulo 2**DATA_WIDTH.
//  Table writes:
//   - Accepted in any state; take effect the next cycle.
//   - A comparison in the same cycle uses the old contents.
//   - Entries already scanned are not revisited.
//   - A write clears that entry's pkt/byte counters; if it coincides with a hit update on the same entry, the clear wins.
//  Reset mid-scan or mid-RESP:
//   - The lookup is discarded; no lu_ack, result or stats are produced for it afterwards.
// TESTING
//  1. After reset, lu_req with empty table -> lu_ack cycle 1; result_valid cycle 17 (depth 16), hit=0; miss_cnt=1.
//  2. Entry 5: key=K, mask all-ones, action 0xA5. Request K, len 64 -> hit=1, index 5, action 0xA5, result_valid cycle 7;
//     stat_rd_addr=5 -> pkt 1, byte 64.
//  3. Entries 3 and 9 both match (entry 9 with mask 0) -> index 3 reported; entry 9 stats unchanged.
//  4. Hold result_ready=0 for 10 cycles, with lu_req high again -> result stable, no second lu_ack until 1 cycle after handshake.
//  5. Overwrite entry 2 with valid=0 while the scan is at idx 1 -> entry 2 misses; write at idx 2 cycle -> old entry still matches.
//  6. Pulse aresetn low during SCAN -> all outputs 0 immediately; next request behaves as scenario 1.

Source files
------------

// File: rtl/flow_lookup_responder.sv
// Flow-table responder: accepts one lookup at a time, scans a masked exact-match
// table one entry per cycle (lowest index wins) and keeps hit/miss and per-entry stats.
module flow_lookup_responder #(
    parameter int OPENFLOW_MATCH_SIZE   = 256,
    parameter int C_AXIS_LEN_DATA_WIDTH = 16,
    parameter int ENTRY_ADDR_WIDTH      = 4,
    parameter int ACTION_WIDTH          = 32,
    parameter int DATA_WIDTH            = 32
) (
    input  logic                             asclk,
    input  logic                             aresetn,
    input  logic                             lu_req,
    input  logic [OPENFLOW_MATCH_SIZE-1:0]   lu_entry,
    input  logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_len,
    output logic                             lu_ack,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic                             result_hit,
    output logic [ENTRY_ADDR_WIDTH-1:0]      result_index,
    output logic [ACTION_WIDTH-1:0]          result_action,
    input  logic                             tbl_wr_en,
    input  logic [ENTRY_ADDR_WIDTH-1:0]      tbl_wr_addr,
    input  logic                             tbl_wr_valid,
    input  logic [OPENFLOW_MATCH_SIZE-1:0]   tbl_wr_key,
    input  logic [OPENFLOW_MATCH_SIZE-1:0]   tbl_wr_mask,
    input  logic [ACTION_WIDTH-1:0]          tbl_wr_action,
    input  logic [ENTRY_ADDR_WIDTH-1:0]      stat_rd_addr,
    output logic [DATA_WIDTH-1:0]            stat_pkt_cnt,
    output logic [DATA_WIDTH-1:0]            stat_byte_cnt,
    output logic [DATA_WIDTH-1:0]            hit_cnt,
    output logic [DATA_WIDTH-1:0]            miss_cnt
);

    localparam int NUM_ENTRIES = 1 << ENTRY_ADDR_WIDTH;

    // Result port handshake: result_* are held stable while result_valid=1 and
    // result_ready=0; the result is consumed on the edge where both are high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                             state;
    logic [OPENFLOW_MATCH_SIZE-1:0]     entry_q;
    logic [C_AXIS_LEN_DATA_WIDTH-1:0]   len_q;
    logic [ENTRY_ADDR_WIDTH-1:0]        scan_idx;

    logic                               tbl_valid  [NUM_ENTRIES];
    logic [OPENFLOW_MATCH_SIZE-1:0]     tbl_key    [NUM_ENTRIES];
    logic [OPENFLOW_MATCH_SIZE-1:0]     tbl_mask   [NUM_ENTRIES];
    logic [ACTION_WIDTH-1:0]            tbl_action [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]              pkt_cnt    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]              byte_cnt   [NUM_ENTRIES];

    logic cur_match;
    logic last_idx;
    logic hit_now;

    always_comb begin
        cur_match = tbl_valid[scan_idx] &&
                    (((tbl_key[scan_idx] ^ entry_q) & tbl_mask[scan_idx]) == '0);
        last_idx  = (scan_idx == ENTRY_ADDR_WIDTH'(NUM_ENTRIES - 1));
        hit_now   = (state == SCAN) && cur_match;
    end

    // Table storage: a write lands on the next edge, so a same-cycle compare sees old contents.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_key[i]    <= '0;
                tbl_mask[i]   <= '0;
                tbl_action[i] <= '0;
            end
        end else if (tbl_wr_en) begin
            tbl_valid[tbl_wr_addr]  <= tbl_wr_valid;
            tbl_key[tbl_wr_addr]    <= tbl_wr_key;
            tbl_mask[tbl_wr_addr]   <= tbl_wr_mask;
            tbl_action[tbl_wr_addr] <= tbl_wr_action;
        end
    end

    // Per-entry statistics; rewriting an entry clears its counters, even over a same-cycle hit.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pkt_cnt[i]  <= '0;
                byte_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (tbl_wr_en && (tbl_wr_addr == ENTRY_ADDR_WIDTH'(i))) begin
                    pkt_cnt[i]  <= '0;
                    byte_cnt[i] <= '0;
                end else if (hit_now && (scan_idx == ENTRY_ADDR_WIDTH'(i))) begin
                    pkt_cnt[i]  <= pkt_cnt[i] + 1'b1;
                    byte_cnt[i] <= byte_cnt[i] + DATA_WIDTH'(len_q);
                end
            end
        end
    end

    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkt_cnt  <= '0;
            stat_byte_cnt <= '0;
        end else begin
            stat_pkt_cnt  <= pkt_cnt[stat_rd_addr];
            stat_byte_cnt <= byte_cnt[stat_rd_addr];
        end
    end

    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            entry_q       <= '0;
            len_q         <= '0;
            scan_idx      <= '0;
            lu_ack        <= 1'b0;
            result_valid  <= 1'b0;
            result_hit    <= 1'b0;
            result_index  <= '0;
            result_action <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            lu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (lu_req) begin
                        entry_q  <= lu_entry;
                        len_q    <= lu_len;
                        scan_idx <= '0;
                        lu_ack   <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_match) begin
                        result_valid  <= 1'b1;
                        result_hit    <= 1'b1;
                        result_index  <= scan_idx;
                        result_action <= tbl_action[scan_idx];
                        hit_cnt       <= hit_cnt + 1'b1;
                        state         <= RESP;
                    end else if (last_idx) begin
                        result_valid  <= 1'b1;
                        result_hit    <= 1'b0;
                        result_index  <= '0;
                        result_action <= '0;
                        miss_cnt      <= miss_cnt + 1'b1;
                        state         <= RESP;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                RESP: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flow_lookup_responder.sv
// Self-checking bench for flow_lookup_responder: reference table model feeding an
// expected-result queue, one task per scenario.
module tb_flow_lookup_responder;

    localparam int MW  = 256;
    localparam int LW  = 16;
    localparam int AW  = 4;
    localparam int ACW = 32;
    localparam int DW  = 32;
    localparam int NE  = 16;
    localparam int EW  = 1 + AW + ACW + 8;

    logic            asclk;
    logic            aresetn;
    logic            lu_req;
    logic [MW-1:0]   lu_entry;
    logic [LW-1:0]   lu_len;
    logic            lu_ack;
    logic            result_valid;
    logic            result_ready;
    logic            result_hit;
    logic [AW-1:0]   result_index;
    logic [ACW-1:0]  result_action;
    logic            tbl_wr_en;
    logic [AW-1:0]   tbl_wr_addr;
    logic            tbl_wr_valid;
    logic [MW-1:0]   tbl_wr_key;
    logic [MW-1:0]   tbl_wr_mask;
    logic [ACW-1:0]  tbl_wr_action;
    logic [AW-1:0]   stat_rd_addr;
    logic [DW-1:0]   stat_pkt_cnt;
    logic [DW-1:0]   stat_byte_cnt;
    logic [DW-1:0]   hit_cnt;
    logic [DW-1:0]   miss_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    logic [EW-1:0] exp_q[$];

    logic           m_valid [NE];
    logic [MW-1:0]  m_key   [NE];
    logic [MW-1:0]  m_mask  [NE];
    logic [ACW-1:0] m_act   [NE];
    logic [DW-1:0]  m_pkt   [NE];
    logic [DW-1:0]  m_byte  [NE];
    logic [DW-1:0]  m_hits;
    logic [DW-1:0]  m_misses;

    logic [MW-1:0]  key_a, key_b, key_c;

    flow_lookup_responder dut (
        .asclk(asclk), .aresetn(aresetn),
        .lu_req(lu_req), .lu_entry(lu_entry), .lu_len(lu_len), .lu_ack(lu_ack),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_hit(result_hit), .result_index(result_index), .result_action(result_action),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_valid(tbl_wr_valid),
        .tbl_wr_key(tbl_wr_key), .tbl_wr_mask(tbl_wr_mask), .tbl_wr_action(tbl_wr_action),
        .stat_rd_addr(stat_rd_addr), .stat_pkt_cnt(stat_pkt_cnt), .stat_byte_cnt(stat_byte_cnt),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // clock / reset
    initial asclk = 1'b0;
    always #5 asclk = ~asclk;
    always @(posedge asclk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge asclk);
        #1;
    endtask

    function automatic logic [MW-1:0] rand_key();
        logic [MW-1:0] k;
        for (int i = 0; i < MW / 32; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0; m_key[i] = '0; m_mask[i] = '0; m_act[i] = '0;
            m_pkt[i] = '0; m_byte[i] = '0;
        end
        m_hits = '0;
        m_misses = '0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic v, input logic [MW-1:0] k,
                               input logic [MW-1:0] m, input logic [ACW-1:0] act);
        m_valid[a] = v; m_key[a] = k; m_mask[a] = m; m_act[a] = act;
        m_pkt[a] = '0; m_byte[a] = '0;
    endtask

    // driver tasks
    task automatic drive_write(input logic [AW-1:0] a, input logic v, input logic [MW-1:0] k,
                               input logic [MW-1:0] m, input logic [ACW-1:0] act);
        tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_valid = v;
        tbl_wr_key = k; tbl_wr_mask = m; tbl_wr_action = act;
        model_write(a, v, k, m, act);
    endtask

    task automatic tbl_write(input logic [AW-1:0] a, input logic v, input logic [MW-1:0] k,
                             input logic [MW-1:0] m, input logic [ACW-1:0] act);
        drive_write(a, v, k, m, act);
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic predict(input logic [MW-1:0] k, input logic [LW-1:0] len,
                           output logic [EW-1:0] e);
        int found = -1;
        for (int i = 0; i < NE; i++)
            if (found < 0 && m_valid[i] && (((m_key[i] ^ k) & m_mask[i]) == '0)) found = i;
        if (found >= 0) begin
            e = {1'b1, AW'(found), m_act[found], 8'(2 + found)};
            m_hits = m_hits + 1;
            m_pkt[found] = m_pkt[found] + 1;
            m_byte[found] = m_byte[found] + DW'(len);
        end else begin
            e = {1'b0, AW'(0), ACW'(0), 8'(NE + 1)};
            m_misses = m_misses + 1;
        end
    endtask

    task automatic send_req(input logic [MW-1:0] k, input logic [LW-1:0] len);
        logic got = 1'b0;
        lu_entry = k; lu_len = len; lu_req = 1'b1;
        t0 = cyc;
        for (int n = 0; n < 5 && !got; n++) begin
            @(negedge asclk);
            if (lu_ack) got = 1'b1;
        end
        total++;
        if (!got || (cyc - t0) != 1) begin
            bad++;
            $display("FAIL ack_cycle: got cycle %0d (seen=%0b) exp cycle 1", cyc - t0, got);
        end
        tick();
        lu_req = 1'b0;
    endtask

    task automatic wait_result(output logic [EW-1:0] obs);
        logic got = 1'b0;
        obs = '1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge asclk);
            if (result_valid) begin
                got = 1'b1;
                obs = {result_hit, result_index, result_action, 8'(cyc - t0)};
            end
        end
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
    endtask

    task automatic read_stats(input logic [AW-1:0] a, output logic [DW-1:0] p,
                              output logic [DW-1:0] b);
        stat_rd_addr = a;
        @(posedge asclk);
        @(negedge asclk);
        p = stat_pkt_cnt;
        b = stat_byte_cnt;
        tick();
    endtask

    // scenarios
    task automatic test_reset();
        logic [EW-1:0] e, obs;
        aresetn = 1'b0;
        repeat (3) @(posedge asclk);
        #1;
        total++;
        if ({lu_ack, result_valid, result_hit, result_index, result_action} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got %h exp 0",
                     {lu_ack, result_valid, result_hit, result_index, result_action});
        end
        total++;
        if ({stat_pkt_cnt, stat_byte_cnt, hit_cnt, miss_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_cnt: got %h exp 0", {stat_pkt_cnt, stat_byte_cnt, hit_cnt, miss_cnt});
        end
        aresetn = 1'b1;
        model_clear();
        tick();
        predict(rand_key(), 16'd80, e);
        exp_q.push_back(e);
        send_req(lu_entry, 16'd80);
        wait_result(obs);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL empty_miss: got %h exp %h", obs, e);
        end
        consume();
        total++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            bad++;
            $display("FAIL empty_counts: got miss=%0d hit=%0d exp miss=1 hit=0", miss_cnt, hit_cnt);
        end
    endtask

    task automatic test_exact_hit();
        logic [EW-1:0] e, obs;
        logic [DW-1:0] p, b;
        key_a = rand_key();
        tbl_write(4'd5, 1'b1, key_a, '1, 32'hA5);
        predict(key_a, 16'd64, e);
        exp_q.push_back(e);
        send_req(key_a, 16'd64);
        wait_result(obs);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL exact_hit: got %h exp %h", obs, e);
        end
        consume();
        read_stats(4'd5, p, b);
        total++;
        if (p !== 32'd1 || b !== 32'd64) begin
            bad++;
            $display("FAIL entry5_stats: got pkt=%0d byte=%0d exp pkt=1 byte=64", p, b);
        end
        total++;
        if (hit_cnt !== 32'd1) begin
            bad++;
            $display("FAIL hit_cnt_1: got %0d exp 1", hit_cnt);
        end
    endtask

    task automatic test_priority();
        logic [EW-1:0] e, obs;
        logic [DW-1:0] p, b;
        key_b = rand_key();
        tbl_write(4'd3, 1'b1, key_b, '1, 32'h33);
        tbl_write(4'd9, 1'b1, rand_key(), '0, 32'h99);
        predict(key_b, 16'd100, e);
        exp_q.push_back(e);
        send_req(key_b, 16'd100);
        wait_result(obs);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL priority: got %h exp %h", obs, e);
        end
        consume();
        read_stats(4'd9, p, b);
        total++;
        if (p !== 32'd0 || b !== 32'd0) begin
            bad++;
            $display("FAIL entry9_stats: got pkt=%0d byte=%0d exp 0 0", p, b);
        end
        read_stats(4'd3, p, b);
        total++;
        if (p !== 32'd1 || b !== 32'd100) begin
            bad++;
            $display("FAIL entry3_stats: got pkt=%0d byte=%0d exp pkt=1 byte=100", p, b);
        end
        tbl_write(4'd9, 1'b0, '0, '0, '0);
    endtask

    task automatic test_random();
        logic [EW-1:0] e, obs;
        logic [MW-1:0] k;
        logic [LW-1:0] len;
        logic [DW-1:0] p, b;
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 3))
                0: k = key_a;
                1: k = key_b;
                default: k = rand_key();
            endcase
            len = LW'($urandom_range(1, 1500));
            predict(k, len, e);
            exp_q.push_back(e);
            send_req(k, len);
            wait_result(obs);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL random_%0d: got %h exp %h", n, obs, e);
            end
            consume();
        end
        total++;
        if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
            bad++;
            $display("FAIL random_totals: got hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
        read_stats(4'd5, p, b);
        total++;
        if (p !== m_pkt[5] || b !== m_byte[5]) begin
            bad++;
            $display("FAIL random_e5: got %0d/%0d exp %0d/%0d", p, b, m_pkt[5], m_byte[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e, obs, e2;
        logic [AW+ACW:0] snap;
        result_ready = 1'b0;
        predict(key_a, 16'd10, e);
        exp_q.push_back(e);
        predict(key_b, 16'd20, e2);
        exp_q.push_back(e2);
        send_req(key_a, 16'd10);
        wait_result(obs);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL bp_first: got %h exp %h", obs, e);
        end
        snap = {result_hit, result_index, result_action};
        tick();
        lu_entry = key_b; lu_len = 16'd20; lu_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge asclk);
            total++;
            if ({result_valid, result_hit, result_index, result_action, lu_ack} !== {1'b1, snap, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold_%0d: got %h exp %h", n,
                         {result_valid, result_hit, result_index, result_action, lu_ack}, {1'b1, snap, 1'b0});
            end
        end
        result_ready = 1'b1;
        tick();
        t0 = cyc;
        @(negedge asclk);
        total++;
        if (lu_ack !== 1'b0 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got ack=%0b valid=%0b exp 0 0", lu_ack, result_valid);
        end
        @(negedge asclk);
        total++;
        if (lu_ack !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_ack: got %0b exp 1", lu_ack);
        end
        tick();
        lu_req = 1'b0;
        wait_result(obs);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL bp_second: got %h exp %h", obs, e);
        end
        consume();
    endtask

    task automatic test_write_during_scan();
        logic [EW-1:0] obs;
        logic [DW-1:0] p, b;
        key_c = rand_key();
        tbl_write(4'd2, 1'b1, key_c, '1, 32'h22);
        // write lands while idx 1 is compared: entry 2 already gone at idx 2
        lu_entry = key_c; lu_len = 16'd40; lu_req = 1'b1;
        t0 = cyc;
        tick();
        lu_req = 1'b0;
        tick();
        drive_write(4'd2, 1'b0, key_c, '1, 32'h22);
        tick();
        tbl_wr_en = 1'b0;
        exp_q.push_back({1'b0, 4'd0, 32'd0, 8'd17});
        m_misses = m_misses + 1;
        wait_result(obs);
        total++;
        if (obs !== exp_q[0]) begin
            bad++;
            $display("FAIL wr_early: got %h exp %h", obs, exp_q[0]);
        end
        void'(exp_q.pop_front());
        consume();
        tbl_write(4'd2, 1'b1, key_c, '1, 32'h22);
        // write in the idx 2 cycle: old entry still matches, but its counters clear
        lu_entry = key_c; lu_len = 16'd50; lu_req = 1'b1;
        t0 = cyc;
        tick();
        lu_req = 1'b0;
        tick();
        tick();
        drive_write(4'd2, 1'b0, key_c, '1, 32'h22);
        tick();
        tbl_wr_en = 1'b0;
        exp_q.push_back({1'b1, 4'd2, 32'h22, 8'd4});
        m_hits = m_hits + 1;
        wait_result(obs);
        total++;
        if (obs !== exp_q[0]) begin
            bad++;
            $display("FAIL wr_same_cycle: got %h exp %h", obs, exp_q[0]);
        end
        void'(exp_q.pop_front());
        consume();
        read_stats(4'd2, p, b);
        total++;
        if (p !== 32'd0 || b !== 32'd0) begin
            bad++;
            $display("FAIL wr_clear_wins: got pkt=%0d byte=%0d exp 0 0", p, b);
        end
        total++;
        if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
            bad++;
            $display("FAIL wr_totals: got hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [EW-1:0] e, obs;
        logic seen = 1'b0;
        send_req(rand_key(), 16'd30);
        repeat (3) tick();
        #3;
        aresetn = 1'b0;
        #1;
        total++;
        if ({lu_ack, result_valid, result_hit, result_index, result_action,
             stat_pkt_cnt, stat_byte_cnt, hit_cnt, miss_cnt} !== '0) begin
            bad++;
            $display("FAIL midscan_reset_outputs: got %h exp 0",
                     {lu_ack, result_valid, result_hit, result_index, result_action,
                      stat_pkt_cnt, stat_byte_cnt, hit_cnt, miss_cnt});
        end
        tick();
        aresetn = 1'b1;
        model_clear();
        repeat (25) begin
            @(negedge asclk);
            if (lu_ack || result_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || miss_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
            bad++;
            $display("FAIL midscan_discard: got seen=%0b miss=%0d hit=%0d exp 0 0 0", seen, miss_cnt, hit_cnt);
        end
        tick();
        predict(rand_key(), 16'd64, e);
        exp_q.push_back(e);
        send_req(lu_entry, 16'd64);
        wait_result(obs);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL post_reset_miss: got %h exp %h", obs, e);
        end
        consume();
        total++;
        if (miss_cnt !== 32'd1) begin
            bad++;
            $display("FAIL post_reset_miss_cnt: got %0d exp 1", miss_cnt);
        end
    endtask

    initial begin
        aresetn = 1'b0; lu_req = 1'b0; lu_entry = '0; lu_len = '0; result_ready = 1'b1;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_valid = 1'b0; tbl_wr_key = '0;
        tbl_wr_mask = '0; tbl_wr_action = '0; stat_rd_addr = '0;
        test_reset();
        test_exact_hit();
        test_priority();
        test_random();
        test_back_to_back();
        test_write_during_scan();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
